// File: rtl/alu_multiciclo_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_multiciclo_if
// Description : Operand/result handshake bundle for alu_multiciclo.
//               The master side supplies operands and consumes results.
//               The slave side is the ALU itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_multiciclo_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] src1;
  logic [N-1:0] src2;
  logic [2:0]   alucontrol;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] num;
  logic         neg;
  logic         cero;
  logic         carry;
  logic         des;
  logic         err;

  modport master (
    output in_valid, src1, src2, alucontrol, out_ready,
    input  in_ready, out_valid, num, neg, cero, carry, des, err
  );

  modport slave (
    input  in_valid, src1, src2, alucontrol, out_ready,
    output in_ready, out_valid, num, neg, cero, carry, des, err
  );
endinterface
`default_nettype wire

// File: rtl/alu_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : alu_multiciclo
// Description : Handshaked ALU with registered result and flags.
//               ADD/SUB/AND/OR/XOR/SLL/SRL complete one cycle after accept.
//               Define ALU_MUL_EN to build the N-step shift-add multiplier
//               for op 111. Without it, op 111 finishes in one cycle with
//               num=0 and err=1.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_multiciclo #(
  parameter int N = 32
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  alu_multiciclo_if.slave bus
);
  localparam int SHW = $clog2(N);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_XOR = 3'b100;
  localparam logic [2:0] c_OP_SLL = 3'b101;
  localparam logic [2:0] c_OP_SRL = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic         r_out_valid;
  logic [N-1:0] r_num;
  logic         r_neg, r_cero, r_carry, r_des, r_err;

  logic         w_accept;
  logic         w_is_mul;
  logic         w_mul_done;
  logic [N-1:0] w_mul_num;
  logic         w_mul_carry;

  logic [N-1:0]   w_num;
  logic           w_neg, w_carry, w_des, w_err;
  logic [SHW-1:0] w_shamt;
  logic [N:0]     w_sum;
  logic [N:0]     w_shl;
  logic [N:0]     w_shr;

  // Ready whenever nothing is pending, or the pending result leaves this cycle.
  // Held low during reset so every output reads 0 while rst_n is asserted.
  assign bus.in_ready = rst_n & ((r_state == S_IDLE) | ((r_state == S_DONE) & bus.out_ready));
  assign w_accept     = bus.in_valid & bus.in_ready;

  assign w_shamt = bus.src2[SHW-1:0];
  assign w_sum   = {1'b0, bus.src1} + {1'b0, bus.src2};
  // Extra bit on the outgoing side captures the last bit shifted out (0 when shift is 0).
  assign w_shl   = {1'b0, bus.src1} << w_shamt;
  assign w_shr   = {bus.src1, 1'b0} >> w_shamt;

  // Single-cycle result and flags for the operation presented on the bus.
  always_comb begin
    w_num   = '0;
    w_neg   = 1'b0;
    w_carry = 1'b0;
    w_des   = 1'b0;
    w_err   = 1'b0;
    case (bus.alucontrol)
      c_OP_ADD: begin
        w_num   = w_sum[N-1:0];
        w_carry = w_sum[N];
        w_des   = (bus.src1[N-1] == bus.src2[N-1]) & (w_sum[N-1] != bus.src1[N-1]);
      end
      c_OP_SUB: begin
        w_neg = (bus.src1 < bus.src2);
        w_num = w_neg ? (bus.src2 - bus.src1) : (bus.src1 - bus.src2);
      end
      c_OP_AND: w_num = bus.src1 & bus.src2;
      c_OP_OR:  w_num = bus.src1 | bus.src2;
      c_OP_XOR: w_num = bus.src1 ^ bus.src2;
      c_OP_SLL: {w_carry, w_num} = w_shl;
      c_OP_SRL: {w_num, w_carry} = w_shr;
      default: begin
`ifndef ALU_MUL_EN
        w_err = 1'b1;
`endif
      end
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [2:0]   c_OP_MUL  = 3'b111;
  localparam logic [SHW:0] c_CNT_END = (SHW+1)'(N);

  // Product register holds {partial high half, remaining multiplier bits}.
  logic [2*N-1:0] r_prod;
  logic [N-1:0]   r_mcand;
  logic [SHW:0]   r_cnt;
  logic [N:0]     w_step_sum;

  assign w_is_mul    = (bus.alucontrol == c_OP_MUL);
  assign w_mul_done  = (r_state == S_BUSY) && (r_cnt == c_CNT_END);
  assign w_step_sum  = {1'b0, r_prod[2*N-1:N]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_num   = r_prod[N-1:0];
  assign w_mul_carry = |r_prod[2*N-1:N];

  // Shift-add multiplier: latch operands at accept, then one step per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod  <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
    end else if (w_accept && w_is_mul) begin
      r_prod  <= {{N{1'b0}}, bus.src2};
      r_mcand <= bus.src1;
      r_cnt   <= '0;
    end else if ((r_state == S_BUSY) && (r_cnt != c_CNT_END)) begin
      r_prod  <= {w_step_sum, r_prod[N-1:1]};
      r_cnt   <= r_cnt + (SHW+1)'(1);
    end
  end
`else
  assign w_is_mul    = 1'b0;
  assign w_mul_done  = 1'b0;
  assign w_mul_num   = '0;
  assign w_mul_carry = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: a new op may be taken in the same cycle the old result leaves.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
      S_BUSY: if (w_mul_done) w_state_nxt = S_DONE;
      S_DONE: begin
        if (bus.out_ready) begin
          if (w_accept) w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
          else          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result registers: load on single-cycle accept or multiplier completion, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_num       <= '0;
      r_neg       <= 1'b0;
      r_cero      <= 1'b0;
      r_carry     <= 1'b0;
      r_des       <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out_valid <= 1'b1;
      r_num       <= w_num;
      r_neg       <= w_neg;
      r_cero      <= (w_num == '0);
      r_carry     <= w_carry;
      r_des       <= w_des;
      r_err       <= w_err;
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
    end else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_num       <= w_mul_num;
      r_neg       <= 1'b0;
      r_cero      <= (w_mul_num == '0);
      r_carry     <= w_mul_carry;
      r_des       <= 1'b0;
      r_err       <= 1'b0;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.num       = r_num;
  assign bus.neg       = r_neg;
  assign bus.cero      = r_cero;
  assign bus.carry     = r_carry;
  assign bus.des       = r_des;
  assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_multiciclo
// Description : Self-checking bench for alu_multiciclo (N=32). Directed
//               corner cases, back-to-back/back-pressure, mid-stream reset
//               and randomized ops against an arithmetic reference model.
//               Honours ALU_MUL_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_multiciclo;
  localparam int N = 32;
`ifdef ALU_MUL_EN
  localparam int MUL_LAT = N + 1;
`else
  localparam int MUL_LAT = 1;
`endif
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -MAXS - 1;

  typedef struct packed {
    logic [31:0] num;
    logic        neg;
    logic        cero;
    logic        carry;
    logic        des;
    logic        err;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  alu_multiciclo_if #(.N(N)) bus ();
  alu_multiciclo #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Reference model written from the arithmetic rules of each op.
  function automatic res_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    int          sh;
    longint      ssum;
    logic [32:0] s33;
    logic [63:0] p;
    r  = '0;
    sh = int'(b[4:0]);
    case (op)
      3'd0: begin
        s33     = {1'b0, a} + {1'b0, b};
        r.num   = s33[31:0];
        r.carry = s33[32];
        ssum    = longint'($signed(a)) + longint'($signed(b));
        r.des   = (ssum > MAXS) || (ssum < MINS);
      end
      3'd1: begin
        r.neg = (a < b);
        r.num = (a < b) ? (b - a) : (a - b);
      end
      3'd2: r.num = a & b;
      3'd3: r.num = a | b;
      3'd4: r.num = a ^ b;
      3'd5: begin
        r.num   = a << sh;
        r.carry = (sh == 0) ? 1'b0 : a[32-sh];
      end
      3'd6: begin
        r.num   = a >> sh;
        r.carry = (sh == 0) ? 1'b0 : a[sh-1];
      end
      default: begin
`ifdef ALU_MUL_EN
        p       = 64'(a) * 64'(b);
        r.num   = p[31:0];
        r.carry = (p[63:32] != 32'd0);
`else
        p       = '0;
        r.num   = p[31:0];
        r.err   = 1'b1;
`endif
      end
    endcase
    r.cero = (r.num == 32'd0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {bus.neg, bus.cero, bus.carry, bus.des, bus.err};
  endfunction

  // One full transaction: accept, latency, result, optional back-pressure hold, drop.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int stall);
    res_t e;
    int   lat;
    e = model(op, a, b);
    @(negedge clk);
    bus.alucontrol = op;
    bus.src1       = a;
    bus.src2       = b;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b1;
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(1));
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.src1      = $urandom;
    bus.src2      = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'((op == 3'b111) ? MUL_LAT : 1));
    check({tag, ".num"}, 64'(bus.num), 64'(e.num));
    check({tag, ".flags"}, 64'(flags()), 64'({e.neg, e.cero, e.carry, e.des, e.err}));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, ".hold"}, {31'd0, bus.out_valid, bus.num}, {31'd0, 1'b1, e.num});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, ".drop"}, 64'(bus.out_valid), 64'(0));
  endtask

  initial begin
    res_t e_add, e_and, e_or, e_xor;
    int   seen;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.src1       = '0;
    bus.src2       = '0;
    bus.alucontrol = '0;

    // Power-on reset
    repeat (3) @(negedge clk);
    check("rst.outs", {26'd0, bus.out_valid, bus.num, flags()}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready", 64'(bus.in_ready), 64'(1));

    // Directed corner cases
    do_op("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'h1, 0);
    do_op("add_ovf",  3'd0, 32'h7FFF_FFFF, 32'h1, 1);
    do_op("sub_neg",  3'd1, 32'd5, 32'd9, 0);
    do_op("sub_zero", 3'd1, 32'd9, 32'd9, 0);
    do_op("sll_1",    3'd5, 32'h8000_0001, 32'd1, 0);
    do_op("srl_0",    3'd6, 32'h3, 32'd0, 0);
    do_op("sll_31",   3'd5, 32'h0000_0003, 32'd31, 0);
    do_op("srl_31",   3'd6, 32'h4000_0000, 32'd31, 0);
    do_op("mul_hi",   3'd7, 32'h0001_0000, 32'h0001_0000, 2);

    // Back-to-back ADD, AND, OR then back-pressure
    e_add = model(3'd0, 32'h1234_5678, 32'h1111_1111);
    e_and = model(3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    e_or  = model(3'd3, 32'hA000_0005, 32'h0500_00A0);
    e_xor = model(3'd4, 32'hFFFF_0000, 32'h0F0F_0F0F);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.alucontrol = 3'd0; bus.src1 = 32'h1234_5678; bus.src2 = 32'h1111_1111;
    @(negedge clk);
    check("b2b.add", {31'd0, bus.out_valid, bus.num}, {31'd0, 1'b1, e_add.num});
    bus.alucontrol = 3'd2; bus.src1 = 32'hF0F0_F0F0; bus.src2 = 32'h0FF0_0FF0;
    @(negedge clk);
    check("b2b.and", {31'd0, bus.out_valid, bus.num}, {31'd0, 1'b1, e_and.num});
    bus.alucontrol = 3'd3; bus.src1 = 32'hA000_0005; bus.src2 = 32'h0500_00A0;
    @(negedge clk);
    check("b2b.or", {31'd0, bus.out_valid, bus.num}, {31'd0, 1'b1, e_or.num});
    bus.out_ready  = 1'b0;
    bus.alucontrol = 3'd4; bus.src1 = 32'hFFFF_0000; bus.src2 = 32'h0F0F_0F0F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp.hold", {30'd0, bus.in_ready, bus.out_valid, bus.num}, {30'd0, 1'b0, 1'b1, e_or.num});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp.xor", {31'd0, bus.out_valid, bus.num}, {31'd0, 1'b1, e_xor.num});
    @(negedge clk);
    check("bp.drop", 64'(bus.out_valid), 64'(0));
    bus.out_ready = 1'b0;

    // Asynchronous reset while a result is held
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alucontrol = 3'd3; bus.src1 = 32'h55; bus.src2 = 32'hAA00;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("arst.pre", {31'd0, bus.out_valid, bus.num}, {31'd0, 1'b1, 32'hAA55});
    #2 rst_n = 1'b0;
    #1 check("arst.outs", {26'd0, bus.out_valid, bus.num, flags()}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst.in_ready", 64'(bus.in_ready), 64'(1));

    // Reset during a multiply: no partial result may surface afterwards
    bus.in_valid = 1'b1; bus.alucontrol = 3'd7; bus.src1 = 32'h1234; bus.src2 = 32'h5678;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < N + 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("mrst.no_result", 64'(seen), 64'(0));
    bus.out_ready = 1'b0;

    // Randomized operations with random back-pressure
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      do_op("rand", rop, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
